dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the core's data-memory port: it accepts load/store requests from the core over a valid/ready handshake, applies a configurable number of wait states, performs byte/halfword/word access with lane selection and sign or zero extension, and returns one response per request. It replaces the zero-latency combinational data memory. It is the target the core's load/store stage talks to once the core is made stall-capable.

## Interface
Parameters:
- DWIDTH, 32, data and address width.
- DEPTH, 256, number of DWIDTH-bit words in the memory array.
- LATENCY, 2, wait cycles between request accept and response; legal range 0–15.

Ports:
- clk, input, 1, the single clock; all state updates on its rising edge.
- rst, input, 1, reset; asynchronous, active-low.
- req_valid, input, 1, request present.
- req_ready, output, 1, responder can accept a request.
- req_we, input, 1, 1 = store, 0 = load.
- req_size, input, 2, access size: 00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as an error).
- req_signed, input, 1, for loads, 1 = sign-extend and 0 = zero-extend; ignored for stores and for word loads.
- req_addr, input, DWIDTH, byte address.
- req_wdata, input, DWIDTH, store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid, output, 1, response present.
- rsp_ready, input, 1, requester accepts the response.
- rsp_rdata, output, DWIDTH, load result; 0 for stores and for errors.
- rsp_err, output, 1, request was misaligned, out of range, or used the reserved size.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch we, size, signed, addr and wdata.
  - Go to WAIT if LATENCY > 0, otherwise go to RESP.
- WAIT:
  - The down-counter is loaded with LATENCY−1 on accept.
  - It decrements every cycle; when it reaches 0, go to RESP.
  - Request inputs are ignored in this state.
- On entry to RESP, the access is performed exactly once:
  - Word index = addr[log2(DEPTH)+1:2].
  - Error if any of the following hold:
    - addr[DWIDTH-1:2] ≥ DEPTH;
    - size = 01 and addr[0] = 1;
    - size = 10 and addr[1:0] ≠ 00;
    - size = 11.
  - On error: no memory write, rdata = 0, err = 1.
  - Store: byte enables come from size and addr[1:0]:
    - byte: lane addr[1:0];
    - half: lanes {addr[1],0} and {addr[1],1};
    - word: all four lanes.
    - Write data is replicated across lanes. Only the enabled lanes change.
  - Load lane select:
    - byte: word[8·addr[1:0] +: 8];
    - half: word[16·addr[1] +: 16].
    - Extension uses the full selected byte or halfword; the MSB of the selected field drives every upper bit when req_signed = 1.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake, go to IDLE.
- Memory contents are not cleared by reset. After reset they are undefined until written.

## Timing
- Reset state: FSM in IDLE, req_ready = 0 while rst is low, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
- req_ready rises on the first clock edge after rst is released, i.e. it is a registered output.
- Accept occurs at edge N, where req_valid && req_ready.
  - req_ready is low from N+1.
  - rsp_valid is high from N+1+LATENCY.
- Response accepted at edge M: rsp_valid is low and req_ready is high from M+1.
  - A new request cannot be accepted in the same cycle as a response handshake.
- Best-case throughput is one request per LATENCY+2 cycles.
- A store is visible to a load accepted at any later edge. There are no read-after-write hazards inside the block.
- rst asserted mid-transaction:
  - Any outstanding request is dropped with no response.
  - A store is committed only if the block had already entered RESP.
  - Outputs take their reset values immediately, asynchronously.
- rsp_ready held high while in IDLE or WAIT has no effect.

## Test plan
- Reset, then word store 0xDEADBEEF to 0x10, then word load from 0x10 with LATENCY = 2 → rsp_valid exactly 3 cycles after the load accept; rdata = 0xDEADBEEF; err = 0.
- With 0xDEADBEEF at 0x10, signed byte loads from 0x10–0x13 → 0xFFFFFFEF, 0xFFFFFFBE, 0xFFFFFFAD, 0xFFFFFFDE. Unsigned load from 0x11 → 0x000000BE. Signed halfword load from 0x12 → 0xFFFFDEAD.
- Byte store 0x55 to 0x12 over 0xDEADBEEF, then word load from 0x10 → 0xDE55BEEF. Halfword store 0x1234 to 0x10 → 0xDE551234.
- Word load from 0x11, halfword load from 0x13, size = 11, and address DEPTH·4 → each gives err = 1 and rdata = 0; a following word load shows memory unchanged.
- Hold rsp_ready low for 5 cycles → rsp_valid, rdata and err stable throughout, req_ready = 0; after the handshake, req_ready = 1 on the next cycle. Repeat with LATENCY = 0 → rsp_valid on the cycle after accept.
- Assert rst during WAIT of a store → no response appears. After release, a load shows the old contents and req_ready comes back one cycle after rst rises.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, configurable wait states, one response out.
// Byte/halfword/word access with lane selection and sign/zero extension on loads.
module dmem_responder #(
   parameter int DWIDTH  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [DWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rsp_err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NB = DWIDTH / 8;
   localparam logic [DWIDTH-1:0] DEPTH_W = DWIDTH'(DEPTH);
   localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic              req_ready_reg, req_ready_next;
   logic              we_reg, signed_reg;
   logic [1:0]        size_reg;
   logic [DWIDTH-1:0] addr_reg, wdata_reg;
   logic [DWIDTH-1:0] rdata_reg;
   logic              err_reg;

   logic [DWIDTH-1:0] mem [DEPTH];

   logic              accept, enter_resp, mem_wr;
   logic              a_we, a_signed, a_err;
   logic [1:0]        a_size;
   logic [DWIDTH-1:0] a_addr, a_wdata;
   logic [AW-1:0]     a_idx;
   logic [DWIDTH-1:0] rd_word, load_data, wr_data;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [NB-1:0]     be;

   assign req_ready = req_ready_reg;
   assign rsp_valid = (state_reg == RESP);
   assign rsp_rdata = rdata_reg;
   assign rsp_err   = err_reg;

   assign accept = req_valid && req_ready_reg;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               if (LATENCY > 0) begin
                  state_next = WAIT;
                  cnt_next   = LAT_M1;
               end else begin
                  state_next = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_reg == 4'd0) begin
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign req_ready_next = (state_next == IDLE);
   assign enter_resp     = (state_next == RESP) && (state_reg != RESP);

   // With zero wait states the access happens on the accept edge, before the latch is loaded.
   assign a_we     = (state_reg == IDLE) ? req_we     : we_reg;
   assign a_size   = (state_reg == IDLE) ? req_size   : size_reg;
   assign a_signed = (state_reg == IDLE) ? req_signed : signed_reg;
   assign a_addr   = (state_reg == IDLE) ? req_addr   : addr_reg;
   assign a_wdata  = (state_reg == IDLE) ? req_wdata  : wdata_reg;
   assign a_idx    = a_addr[AW+1:2];

   assign a_err = (a_size == 2'b11)
               || (a_size == 2'b01 && a_addr[0])
               || (a_size == 2'b10 && a_addr[1:0] != 2'b00)
               || ({2'b00, a_addr[DWIDTH-1:2]} >= DEPTH_W);

   assign rd_word  = mem[a_idx];
   assign byte_sel = rd_word[{a_addr[1:0], 3'b000} +: 8];
   assign half_sel = rd_word[{a_addr[1], 4'b0000} +: 16];

   always_comb begin
      load_data = rd_word;
      wr_data   = a_wdata;
      case (a_size)
         2'b00: begin
            load_data = {{(DWIDTH-8){a_signed & byte_sel[7]}}, byte_sel};
            wr_data   = {NB{a_wdata[7:0]}};
         end
         2'b01: begin
            load_data = {{(DWIDTH-16){a_signed & half_sel[15]}}, half_sel};
            wr_data   = {(NB/2){a_wdata[15:0]}};
         end
         default: begin
            load_data = rd_word;
            wr_data   = a_wdata;
         end
      endcase
   end

   for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi % 4);
      assign be[gi] = (a_size == 2'b10)
                   || (a_size == 2'b00 && a_addr[1:0] == LANE)
                   || (a_size == 2'b01 && a_addr[1] == LANE[1]);
   end

   assign mem_wr = enter_resp && a_we && !a_err;

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
               mem[a_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= 4'd0;
         req_ready_reg <= 1'b0;
         we_reg        <= 1'b0;
         signed_reg    <= 1'b0;
         size_reg      <= 2'b00;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         rdata_reg     <= '0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         req_ready_reg <= req_ready_next;
         if (accept) begin
            we_reg     <= req_we;
            signed_reg <= req_signed;
            size_reg   <= req_size;
            addr_reg   <= req_addr;
            wdata_reg  <= req_wdata;
         end
         // Result is captured once on entry to RESP and then held through any backpressure.
         if (enter_resp) begin
            err_reg   <= a_err;
            rdata_reg <= (a_err || a_we) ? '0 : load_data;
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-addressed reference model with a per-cycle compare process,
// directed request sequences with literal expectations, and a zero-latency instance.
module tb_dmem_responder;
   localparam int DW    = 32;
   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
   logic [1:0]    req_size = 2'b10;
   logic [DW-1:0] req_addr = '0, req_wdata = '0;
   logic          req_ready, rsp_valid, rsp_err;
   logic [DW-1:0] rsp_rdata;

   logic          req_valid_b = 1'b0, rsp_ready_b = 1'b0;
   logic          req_ready_b, rsp_valid_b, rsp_err_b;
   logic [DW-1:0] rsp_rdata_b;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DWIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   dmem_responder #(.DWIDTH(DW), .DEPTH(DEPTH), .LATENCY(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: little-endian byte memory plus one outstanding request.
   logic [7:0] mmem [0:4*DEPTH-1];
   int          cyc = 0;
   logic        ready_ok = 1'b0;
   logic        pend = 1'b0, p_we = 1'b0, p_err = 1'b0, p_applied = 1'b0;
   logic [1:0]  p_size = 2'b00;
   logic [31:0] p_addr = '0, p_wdata = '0, p_rd = '0;
   int          p_due = 0;

   function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
          || ((a >> 2) >= 32'(DEPTH));
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
      logic [31:0] v;
      int n;
      n = 1 << sz;
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(mmem[a + 32'(i)]) << (8 * i));
      if (sg && sz == 2'b00 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
      if (sg && sz == 2'b01 && v >= 32'd32768) v = v + 32'hFFFF_0000;
      return v;
   endfunction

   always @(posedge clk) begin
      cyc++;
      ready_ok = rst;
   end

   always @(negedge clk) begin
      if (!rst) begin
         pend = 1'b0;
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_rsp_rdata", rsp_rdata, 32'd0);
         chk("rst_rsp_err", 32'(rsp_err), 32'd0);
         chk("rst_req_ready", 32'(req_ready), 32'd0);
      end else begin
         if (pend && cyc >= p_due) begin
            if (p_we && !p_err && !p_applied) begin
               for (int i = 0; i < (1 << p_size); i++) mmem[p_addr + 32'(i)] = p_wdata[8*i +: 8];
               p_applied = 1'b1;
            end
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_rdata", rsp_rdata, p_rd);
            chk("rsp_err", 32'(rsp_err), 32'(p_err));
         end else begin
            chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
         end
         chk("req_ready", 32'(req_ready), 32'(ready_ok && !pend));
         if (pend && cyc >= p_due && rsp_ready) begin
            pend = 1'b0;
         end else if (!pend && ready_ok && req_valid) begin
            pend      = 1'b1;
            p_we      = req_we;
            p_size    = req_size;
            p_addr    = req_addr;
            p_wdata   = req_wdata;
            p_err     = m_err(req_size, req_addr);
            p_rd      = (p_err || req_we) ? 32'd0 : m_load(req_size, req_signed, req_addr);
            p_applied = 1'b0;
            p_due     = cyc + 1 + LAT;
         end
      end
   end

   // hold < 0 keeps rsp_ready high for the whole transaction.
   task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int hold,
                         input logic [31:0] lit_rd, input logic lit_err);
      int t;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
      req_addr = a; req_wdata = wd;
      if (hold < 0) rsp_ready = 1'b1;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 20) begin @(negedge clk); t++; end
      if (t >= 20) chk("accept_timeout", 32'(t), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      t = 1;
      @(negedge clk);
      while (!rsp_valid && t < 40) begin @(negedge clk); t++; end
      chk("latency", 32'(t), 32'(LAT + 1));
      chk("lit_rdata", rsp_rdata, lit_rd);
      chk("lit_err", 32'(rsp_err), 32'(lit_err));
      if (hold >= 0) begin
         repeat (hold) @(negedge clk);
         @(posedge clk); #1;
         rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic do_b(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] lit_rd);
      @(posedge clk); #1;
      req_we = we; req_size = 2'b10; req_signed = 1'b0; req_addr = a; req_wdata = wd;
      req_valid_b = 1'b1;
      @(negedge clk);
      chk("b_req_ready", 32'(req_ready_b), 32'd1);
      @(posedge clk); #1;
      req_valid_b = 1'b0;
      rsp_ready_b = 1'b1;
      @(negedge clk);
      chk("b_rsp_valid", 32'(rsp_valid_b), 32'd1);
      chk("b_rsp_rdata", rsp_rdata_b, lit_rd);
      chk("b_rsp_err", 32'(rsp_err_b), 32'd0);
      chk("b_req_ready_busy", 32'(req_ready_b), 32'd0);
      @(posedge clk); #1;
      rsp_ready_b = 1'b0;
      @(negedge clk);
      chk("b_rsp_valid_done", 32'(rsp_valid_b), 32'd0);
      chk("b_req_ready_back", 32'(req_ready_b), 32'd1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 1'b0);
      do_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 1'b0);
      do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 0, 32'hFFFFFFBE, 1'b0);
      do_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 0, 32'hFFFFFFAD, 1'b0);
      do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0, 32'hFFFFFFDE, 1'b0);
      do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 0, 32'h000000BE, 1'b0);
      do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 0, 32'hFFFFDEAD, 1'b0);
      do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 0, 32'h0000DEAD, 1'b0);

      do_req(1'b1, 2'b00, 1'b0, 32'h12, 32'hAAAAAA55, 0, 32'h0, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 32'hDE55BEEF, 1'b0);
      do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'hFFFF1234, 0, 32'h0, 1'b0);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 32'hDE551234, 1'b0);

      do_req(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 0, 32'h0, 1'b1);
      do_req(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 0, 32'h0, 1'b1);
      do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0, 32'h0, 1'b1);
      do_req(1'b0, 2'b10, 1'b0, 32'(DEPTH * 4), 32'h0, 0, 32'h0, 1'b1);
      do_req(1'b1, 2'b10, 1'b0, 32'h12, 32'hFFFFFFFF, 0, 32'h0, 1'b1);
      do_req(1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFFFFFF, 0, 32'h0, 1'b1);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 32'hDE551234, 1'b0);

      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, 32'hDE551234, 1'b0);
      do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, -1, 32'h000000DE, 1'b0);

      // Reset while a store sits in its wait states: it must be dropped.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h10; req_wdata = 32'h11111111;
      @(posedge clk); #1;
      req_valid = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("async_rst_ready", 32'(req_ready), 32'd0);
      chk("async_rst_valid", 32'(rsp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("ready_before_edge", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("ready_after_edge", 32'(req_ready), 32'd1);
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, 32'hDE551234, 1'b0);

      do_b(1'b1, 32'h20, 32'hCAFEF00D, 32'h0);
      do_b(1'b0, 32'h20, 32'h0, 32'hCAFEF00D);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
